// File: rtl/decode_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : decode_queue_if
// Purpose  : Fetch-side and issue-side handshake bundle for decode_queue.
//            "slave" is the decode block; "master" is the surrounding pipe.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface decode_queue_if #(
  parameter int RN_W  = 7,
  parameter int IMM_W = 56
);
  // fetch side
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       inst_raw;
  logic [63:0]       inst_canon;
  logic              inst_bad;
  logic              advance16;
  logic              advance32;
  logic              advance64;
  logic              flush;
  // issue side
  logic              out_valid;
  logic              out_ready;
  logic              out_type;
  logic [2:0]        out_unit;
  logic [1:0]        out_op;
  logic [RN_W-1:0]   out_rd;
  logic [RN_W-1:0]   out_rd2;
  logic [RN_W-1:0]   out_rs1;
  logic [RN_W-1:0]   out_rs2;
  logic [IMM_W-1:0]  out_imm;
  logic              out_use_rs1;
  logic              out_use_rs2;
  logic              out_src2_rd;
  logic              out_bad;
  logic              trapped;

  modport slave (
    input  in_valid, inst_raw, inst_canon, inst_bad, flush, out_ready,
    output in_ready, advance16, advance32, advance64,
    output out_valid, out_type, out_unit, out_op, out_rd, out_rd2,
    output out_rs1, out_rs2, out_imm, out_use_rs1, out_use_rs2,
    output out_src2_rd, out_bad, trapped
  );

  modport master (
    output in_valid, inst_raw, inst_canon, inst_bad, flush, out_ready,
    input  in_ready, advance16, advance32, advance64,
    input  out_valid, out_type, out_unit, out_op, out_rd, out_rd2,
    input  out_rs1, out_rs2, out_imm, out_use_rs1, out_use_rs2,
    input  out_src2_rd, out_bad, trapped
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : decode_queue
// Purpose  : Variable-length instruction decode with a DEPTH-entry output
//            queue, source-use classification, flush and bad-opcode trap.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int RN_W  = 7,
  parameter int IMM_W = 56
) (
  input  logic         clk,
  input  logic         rst,
  decode_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  // Canonical fields 61:0 are kept whole; outputs slice them at the head.
  typedef struct packed {
    logic [61:0] canon;
    logic        use_rs1;
    logic        use_rs2;
    logic        src2_rd;
    logic        bad;
  } entry_t;

  state_t            state_q;
  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  // Slot shown on the outputs: tracks rptr while non-empty, otherwise keeps
  // pointing at the last entry that was the head.
  logic [PTR_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic   w_accept;
  logic   w_pop;
  logic   w_use_rs1;
  logic   w_use_rs2;
  logic   w_src2_rd;
  entry_t w_entry;
  entry_t w_head;
  logic   w_unused_bits;

  logic       w_type;
  logic [2:0] w_unit;
  logic [1:0] w_op;

  assign w_type = bus.inst_canon[61];
  assign w_unit = bus.inst_canon[60:58];
  assign w_op   = bus.inst_canon[57:56];

  assign bus.in_ready  = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH)) && !bus.flush;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (count_q != '0);
  assign w_pop         = bus.out_valid && bus.out_ready && !bus.flush;

  assign bus.advance16 = w_accept && !bus.inst_raw[63];
  assign bus.advance32 = w_accept && (bus.inst_raw[63:62] == 2'b10);
  assign bus.advance64 = w_accept && (bus.inst_raw[63:62] == 2'b11);

  assign w_unused_bits = ^{bus.inst_raw[61:0], bus.inst_canon[63:62]};

  // Source-register usage classification; bad opcodes report no sources.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_src2_rd = 1'b0;
    if (!bus.inst_bad) begin
      if (!w_type) begin
        if (w_unit <= 3'd4 || (w_unit == 3'd7 && w_op == 2'b01)) begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
        end else if (w_unit == 3'd7 && w_op[1]) begin
          w_use_rs1 = 1'b1;
        end
      end else begin
        if (w_unit <= 3'd4 || (w_unit == 3'd5 && w_op != 2'b00)) begin
          w_use_rs1 = 1'b1;
        end else if (w_unit == 3'd6 || (w_unit == 3'd7 && !w_op[1])) begin
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_src2_rd = 1'b1;
        end
      end
    end
  end

  assign w_entry = '{canon:   bus.inst_canon[61:0],
                     use_rs1: w_use_rs1,
                     use_rs2: w_use_rs2,
                     src2_rd: w_src2_rd,
                     bad:     bus.inst_bad};

  // Pointer/count next state; flush wins over accept and pop.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    head_d  = head_q;
    if (bus.flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (w_accept) wptr_d = wptr_q + PTR_W'(1);
      if (w_pop)    rptr_d = rptr_q + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (count_d != '0) head_d = rptr_d;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      head_q  <= head_d;
    end
  end

  // Entry storage, written at the write pointer on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_accept) begin
      mem_q[wptr_q] <= w_entry;
    end
  end

  // RUN/TRAP control: a bad opcode stops decode until flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (w_accept && bus.inst_bad) state_q <= ST_TRAP;
        ST_TRAP: if (bus.flush) state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.trapped = (state_q == ST_TRAP);

  assign w_head          = mem_q[head_q];
  assign bus.out_type    = w_head.canon[61];
  assign bus.out_unit    = w_head.canon[60:58];
  assign bus.out_op      = w_head.canon[57:56];
  assign bus.out_rd      = RN_W'(w_head.canon[55:50]);
  assign bus.out_rd2     = RN_W'(w_head.canon[49:44]);
  assign bus.out_rs1     = RN_W'(w_head.canon[43:38]);
  assign bus.out_rs2     = RN_W'(w_head.canon[37:32]);
  assign bus.out_imm     = IMM_W'(w_head.canon[55:0]);
  assign bus.out_use_rs1 = w_head.use_rs1;
  assign bus.out_use_rs2 = w_head.use_rs2;
  assign bus.out_src2_rd = w_head.src2_rd;
  assign bus.out_bad     = w_head.bad;

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised successor to the single-register decode stage. It accepts one variable-length instruction (16/32/64-bit) per cycle from fetch, extracts fields, and classifies source-register usage. Each decoded instruction is stored in a DEPTH-entry output queue with valid/ready handshakes on both sides. A flush input empties the queue, and a trap state stops decode after a bad opcode. It sits between fetch/canonicaliser and register-read/issue.

Parameters:
DEPTH, 2, output queue entries; power of two, >=2
RN_W, 7, width of each register-number output; 6-bit fields zero-extended; RN_W>=6
IMM_W, 56, immediate output width; canon[55:0] zero-extended or truncated to IMM_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch window holds an instruction
in_ready  out  1  block accepts this cycle
inst_raw  in  64  raw fetch window, instruction left-aligned at bit 63
inst_canon  in  64  canonicalised form of inst_raw (same cycle)
inst_bad  in  1  bad-opcode flag for inst_raw (same cycle)
advance16  out  1  consume 16 bits this cycle
advance32  out  1  consume 32 bits this cycle
advance64  out  1  consume 64 bits this cycle
flush  in  1  discard queue, leave trap state
out_valid  out  1  queue head valid
out_ready  in  1  consumer takes head
out_type  out  1  canon[61]
out_unit  out  3  canon[60:58]
out_op  out  2  canon[57:56]
out_rd  out  RN_W  canon[55:50]
out_rd2  out  RN_W  canon[49:44]
out_rs1  out  RN_W  canon[43:38]
out_rs2  out  RN_W  canon[37:32]
out_imm  out  IMM_W  canon[55:0]
out_use_rs1  out  1  rs1 is a source
out_use_rs2  out  1  second source used
out_src2_rd  out  1  second source is the rd field, not rs2
out_bad  out  1  entry is a bad opcode
trapped  out  1  block is in TRAP state

Behaviour:
- Reset: queue empty; count=0; read and write pointers 0; state RUN. All outputs 0 except in_ready=1.
- States:
  - RUN: in_ready = (count<DEPTH) & ~flush.
  - TRAP: in_ready=0.
  - RUN->TRAP when an entry with inst_bad=1 is accepted.
  - TRAP->RUN on flush.
  - flush in RUN stays in RUN.
- Accept means in_valid & in_ready. On accept, the entry is written at the write pointer in the same clock edge.
- Advance outputs are combinational and gated by accept:
  - advance16 = accept & ~inst_raw[63]
  - advance32 = accept & (inst_raw[63:62]==2'b10)
  - advance64 = accept & (inst_raw[63:62]==2'b11)
  - Exactly one is high when accept=1; all are 0 otherwise.
- Use classification:
  - R-type (type=0):
    - unit<=4, or unit=7 with op=01: use_rs1=1, use_rs2=1.
    - Otherwise, unit=7 with op[1]=1: use_rs1=1.
    - All other R-type: none.
  - I-type (type=1):
    - unit<=4, or unit=5 with op!=00: use_rs1=1.
    - Otherwise, unit=6, or unit=7 with op[1]=0: use_rs1=1, use_rs2=1, src2_rd=1.
    - All other I-type: none.
  - Bad entries store use_* = 0.
- Output fields always reflect the head entry. When the queue is empty they hold the last head values; consumers ignore them when out_valid=0.
- Pop on out_valid & out_ready.
- Accept and pop in the same cycle: count unchanged, both pointers advance.
- Full queue: no accept, even when a pop happens that cycle. There is no bypass; latency in->out is 1 cycle minimum.
- Pointers wrap modulo DEPTH.
- flush:
  - count:=0 and pointers:=0 at the edge.
  - Pop and accept that cycle are ignored.
  - out_valid=0 the next cycle.
- trapped = (state==TRAP). Entries already queued before the bad entry drain normally in TRAP; the bad entry itself is delivered with out_bad=1.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Test Plan:
- Reset release, in_valid=1, inst_raw=0x7xxx... (bit63=0), canon type=0 unit=2 -> advance16 pulses for 1 cycle; next cycle out_valid=1, use_rs1=1, use_rs2=1, out_rs1=canon[43:38].
- Back-to-back 32-bit then 64-bit (raw[63:62]=10, then 11), out_ready=1 -> advance32 then advance64 on consecutive cycles; outputs appear in order, 1 cycle later each.
- out_ready=0 with DEPTH=2: two instructions accepted, third cycle in_ready=0, no advance; raise out_ready -> pop, and a new accept occurs only on the following cycle.
- I-type unit=6, rd=0x15 -> use_rs1=1, use_rs2=1, src2_rd=1, out_rd=0x15 zero-extended to RN_W; RN_W=8 build shows upper 2 bits 0.
- inst_bad=1 accepted behind one good entry -> trapped=1; in_ready=0; good entry then bad entry (out_bad=1) drain; flush -> trapped=0, in_ready=1, out_valid=0.
- Queue holding 2 entries, flush with in_valid=1 and out_ready=1 -> no advance, no pop; next cycle count=0, out_valid=0.
